loop_ctrl: RTL and testbench

LOOP_CTRL -- requirements
Module: loop_ctrl

---
 rtl/loop_ctrl.sv | 107 ++++++++++
 tb/tb_loop_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/loop_ctrl.sv
// Three-level nested loop index generator: START latches bounds, first iteration one cycle later.
// STALL holds the indices without issuing; ABORT returns to IDLE without a DONE pulse.
module loop_ctrl #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [COUNT_WIDTH-1:0] MAX0,
  input  logic [COUNT_WIDTH-1:0] MAX1,
  input  logic [COUNT_WIDTH-1:0] MAX2,
  input  logic                   STALL,
  output logic                   VALID,
  output logic [COUNT_WIDTH-1:0] IDX0,
  output logic [COUNT_WIDTH-1:0] IDX1,
  output logic [COUNT_WIDTH-1:0] IDX2,
  output logic                   LAST,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state;
  logic [COUNT_WIDTH-1:0] bnd0, bnd1, bnd2;
  logic                   wrap0, wrap1, wrap2;
  logic [COUNT_WIDTH-1:0] nxt0, nxt1, nxt2;

  assign wrap0 = (IDX0 == bnd0);
  assign wrap1 = (IDX1 == bnd1);
  assign wrap2 = (IDX2 == bnd2);

  assign VALID = (state == S_RUN) && !STALL;
  assign LAST  = VALID && wrap0 && wrap1 && wrap2;
  assign BUSY  = (state != S_IDLE);
  assign DONE  = (state == S_DONE);

  // Wrapping to zero is explicit, so an all-ones bound never relies on overflow.
  always_comb begin
    nxt0 = IDX0;
    nxt1 = IDX1;
    nxt2 = IDX2;
    nxt0 = wrap0 ? '0 : IDX0 + COUNT_WIDTH'(1);
    if (wrap0) begin
      nxt1 = wrap1 ? '0 : IDX1 + COUNT_WIDTH'(1);
      if (wrap1)
        nxt2 = wrap2 ? '0 : IDX2 + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      IDX0  <= '0;
      IDX1  <= '0;
      IDX2  <= '0;
      bnd0  <= '0;
      bnd1  <= '0;
      bnd2  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START && !ABORT) begin
            state <= S_RUN;
            bnd0  <= MAX0;
            bnd1  <= MAX1;
            bnd2  <= MAX2;
            IDX0  <= '0;
            IDX1  <= '0;
            IDX2  <= '0;
          end
        end
        S_RUN: begin
          if (ABORT) begin
            state <= S_IDLE;
            IDX0  <= '0;
            IDX1  <= '0;
            IDX2  <= '0;
          end else if (VALID) begin
            // On the last iteration every level wraps, leaving the indices at zero.
            IDX0 <= nxt0;
            IDX1 <= nxt1;
            IDX2 <= nxt2;
            if (LAST)
              state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          IDX0  <= '0;
          IDX1  <= '0;
          IDX2  <= '0;
        end
        default: begin
          state <= S_IDLE;
          IDX0  <= '0;
          IDX1  <= '0;
          IDX2  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_ctrl.sv
// Scoreboard bench for loop_ctrl: one 8-bit and one 4-bit instance, directed nests.
module tb_loop_ctrl;

  logic       CLK = 1'b0;
  logic       RESET, START, ABORT, STALL, START4;
  logic [7:0] MAX0, MAX1, MAX2;
  logic [3:0] M40, M41, M42;

  logic       VALID8, LAST8, BUSY8, DONE8;
  logic [7:0] IDX0_8, IDX1_8, IDX2_8;
  logic       VALID4, LAST4, BUSY4, DONE4;
  logic [3:0] IDX0_4, IDX1_4, IDX2_4;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [26:0] q8[$];
  logic [26:0] q4[$];

  always #5 CLK = ~CLK;

  loop_ctrl #(.COUNT_WIDTH(8)) dut8 (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .MAX0(MAX0), .MAX1(MAX1), .MAX2(MAX2), .STALL(STALL),
    .VALID(VALID8), .IDX0(IDX0_8), .IDX1(IDX1_8), .IDX2(IDX2_8),
    .LAST(LAST8), .BUSY(BUSY8), .DONE(DONE8)
  );

  loop_ctrl #(.COUNT_WIDTH(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .START(START4), .ABORT(ABORT),
    .MAX0(M40), .MAX1(M41), .MAX2(M42), .STALL(STALL),
    .VALID(VALID4), .IDX0(IDX0_4), .IDX1(IDX1_4), .IDX2(IDX2_4),
    .LAST(LAST4), .BUSY(BUSY4), .DONE(DONE4)
  );

  function automatic logic [26:0] mk(input logic v, input logic d, input logic l,
                                     input logic [7:0] i2, input logic [7:0] i1,
                                     input logic [7:0] i0);
    return {v, d, l, i2, i1, i0};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [26:0] act8();
    return {VALID8, DONE8, LAST8, IDX2_8, IDX1_8, IDX0_8};
  endfunction

  function automatic logic [26:0] act4();
    return {VALID4, DONE4, LAST4, 4'b0, IDX2_4, 4'b0, IDX1_4, 4'b0, IDX0_4};
  endfunction

  // Monitors: every VALID or DONE cycle must match the next queued expectation.
  always @(negedge CLK) begin
    if (!RESET && (VALID8 || DONE8)) begin
      if (q8.size() == 0) check("sb8_unexpected", {5'b0, act8()}, 32'h0);
      else check("sb8_event", {5'b0, act8()}, {5'b0, q8.pop_front()});
    end
  end

  always @(negedge CLK) begin
    if (!RESET && (VALID4 || DONE4)) begin
      if (q4.size() == 0) check("sb4_unexpected", {5'b0, act4()}, 32'h0);
      else check("sb4_event", {5'b0, act4()}, {5'b0, q4.pop_front()});
    end
  end

  task automatic push_nest(input int b0, input int b1, input int b2, input bit w4);
    for (int i2 = 0; i2 <= b2; i2++)
      for (int i1 = 0; i1 <= b1; i1++)
        for (int i0 = 0; i0 <= b0; i0++) begin
          logic l;
          l = (i0 == b0) && (i1 == b1) && (i2 == b2);
          if (w4) q4.push_back(mk(1'b1, 1'b0, l, 8'(i2), 8'(i1), 8'(i0)));
          else    q8.push_back(mk(1'b1, 1'b0, l, 8'(i2), 8'(i1), 8'(i0)));
        end
    if (w4) q4.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
    else    q8.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
  endtask

  // Called just after a rising edge; returns just after the edge that samples START.
  task automatic start_nest(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    MAX0 = b0; MAX1 = b1; MAX2 = b2; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    MAX0 = 8'hAA; MAX1 = 8'h55; MAX2 = 8'hC3;
  endtask

  task automatic wait_idle(input bit w4, input int n);
    int k = 0;
    @(negedge CLK);
    while ((w4 ? BUSY4 : BUSY8) && k < n) begin
      @(negedge CLK);
      k++;
    end
    check(w4 ? "idle_timeout4" : "idle_timeout8", {31'b0, (w4 ? BUSY4 : BUSY8)}, 32'h0);
    @(posedge CLK); #1;
  endtask

  initial begin
    int k;
    logic       exp_v[6];
    logic [7:0] exp_i[6];
    exp_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_i = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};

    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; STALL = 1'b0; START4 = 1'b0;
    MAX0 = 8'd0; MAX1 = 8'd0; MAX2 = 8'd0; M40 = 4'd0; M41 = 4'd0; M42 = 4'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs8", {5'b0, act8(), BUSY8}, 32'h0);
    check("reset_outputs4", {5'b0, act4(), BUSY4}, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // 1/2/1 nest, then a START during the DONE cycle must be ignored.
    push_nest(1, 2, 1, 1'b0);
    start_nest(8'd1, 8'd2, 8'd1);
    @(negedge CLK);
    check("start_latency", {31'b0, VALID8}, 32'h1);
    k = 0;
    while (!DONE8 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check("done_seen", {31'b0, DONE8}, 32'h1);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    check("start_in_done_ignored", {31'b0, BUSY8}, 32'h0);
    @(posedge CLK); #1;

    // All bounds zero: single LAST iteration.
    push_nest(0, 0, 0, 1'b0);
    start_nest(8'd0, 8'd0, 8'd0);
    wait_idle(1'b0, 20);

    // Stall on the 2nd and 3rd RUN cycles.
    push_nest(3, 0, 0, 1'b0);
    start_nest(8'd3, 8'd0, 8'd0);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge CLK); #1;
      end
      STALL = (c == 1 || c == 2);
      @(negedge CLK);
      check("stall_valid", {31'b0, VALID8}, {31'b0, exp_v[c]});
      check("stall_idx0", {24'b0, IDX0_8}, {24'b0, exp_i[c]});
    end
    @(posedge CLK); #1;
    STALL = 1'b0;
    wait_idle(1'b0, 20);

    // Abort at (1,1,0) with bounds 2/2/2.
    q8.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    q8.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd1));
    q8.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd2));
    q8.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 8'd0));
    q8.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 8'd1));
    start_nest(8'd2, 8'd2, 8'd2);
    repeat (4) @(posedge CLK);
    #1 ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    @(negedge CLK);
    check("abort_idle", {5'b0, BUSY8, DONE8, IDX2_8, IDX1_8, IDX0_8}, 32'h0);
    @(posedge CLK); #1;
    START = 1'b1; ABORT = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; ABORT = 1'b0;
    @(negedge CLK);
    check("abort_beats_start", {31'b0, BUSY8}, 32'h0);
    @(posedge CLK); #1;
    push_nest(2, 2, 2, 1'b0);
    start_nest(8'd2, 8'd2, 8'd2);
    wait_idle(1'b0, 60);

    // Reset mid-nest with START held high.
    q8.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    q8.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd1));
    q8.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd2));
    start_nest(8'd2, 8'd1, 8'd0);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1; START = 1'b1;
    MAX0 = 8'd1; MAX1 = 8'd0; MAX2 = 8'd1;
    repeat (2) begin
      @(posedge CLK);
      @(negedge CLK);
      check("reset_hold", {5'b0, act8(), BUSY8}, 32'h0);
    end
    push_nest(1, 0, 1, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    check("restart_after_reset", {31'b0, VALID8}, 32'h1);
    wait_idle(1'b0, 20);

    // Narrow instance: all-ones inner bound wraps cleanly.
    push_nest(15, 0, 0, 1'b1);
    M40 = 4'd15; M41 = 4'd0; M42 = 4'd0; START4 = 1'b1;
    @(posedge CLK); #1;
    START4 = 1'b0;
    wait_idle(1'b1, 40);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("sb8_drained", q8.size(), 32'h0);
    check("sb4_drained", q4.size(), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
